// File: rtl/jtframe_ddio_rx_pkg.sv
// Shared defaults and word type for the 12-bit DDR pad receiver.
// Optional drop statistics are enabled with the JTFRAME_DDIO_RX_STATS_EN macro.
package jtframe_ddio_rx_pkg;

    localparam int DW_DEF    = 12;
    localparam int DEPTH_DEF = 4;

    typedef logic [2*DW_DEF-1:0] word_t;

    // Saturating 16-bit increment used by the drop counter
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            return 16'hFFFF;
        end else begin
            return val + 16'd1;
        end
    endfunction

endpackage

// File: rtl/jtframe_ddio_rx_fifo.sv
// Capture FIFO for the DDR receiver: registered head word, valid flag and level.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module jtframe_ddio_rx_fifo
    import jtframe_ddio_rx_pkg::*;
#(
    parameter int W     = 2*DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [W-1:0]  head_r;
    logic          valid_r;

    logic          push_ok_s;
    logic [AW-1:0] rd_next_s;
    logic [AW:0]   count_next_s;
    logic [W-1:0]  head_next_s;

    // Acceptance, next level and next head word
    always_comb begin
        full         = (count_r == (AW+1)'(DEPTH));
        push_ok_s    = push && (!full || pop);
        rd_next_s    = rd_ptr_r + AW'(1);
        count_next_s = count_r;
        head_next_s  = head_r;
        case ({push_ok_s, pop})
            2'b10:   count_next_s = count_r + (AW+1)'(1);
            2'b01:   count_next_s = count_r - (AW+1)'(1);
            default: count_next_s = count_r;
        endcase
        // The head register is kept equal to the entry at the read pointer
        if (pop) begin
            if (count_r > (AW+1)'(1)) begin
                head_next_s = mem_r[rd_next_s];
            end else if (push_ok_s) begin
                head_next_s = wdata;
            end else begin
                head_next_s = head_r;
            end
        end else if (count_r == '0 && push_ok_s) begin
            head_next_s = wdata;
        end else begin
            head_next_s = head_r;
        end
    end

    // Storage, pointers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            head_r   <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_next_s;
            end
            count_r <= count_next_s;
            head_r  <= head_next_s;
            valid_r <= (count_next_s != '0);
        end
    end

    assign head  = head_r;
    assign valid = valid_r;
    assign level = count_r;

endmodule

// File: rtl/jtframe_ddio_rx12.sv
// DDR pad receiver: high half on the rising edge, low half on the falling edge, queued as words.
// Define JTFRAME_DDIO_RX_STATS_EN to enable the saturating dropped-word counter.
module jtframe_ddio_rx12
    import jtframe_ddio_rx_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DW-1:0]          padin,
    input  logic                   ie,
    output logic [2*DW-1:0]        dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    input  logic                   clr_ovf,
    output logic [15:0]            drops
);
    logic [DW-1:0] h_q;
    logic [DW-1:0] l_q;
    logic          ie_q;
    logic          ovf_r;
    logic          full_s;
    logic          pop_s;
    logic          overflow_s;

    // Rising-edge capture of the high half and the enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q  <= '0;
            ie_q <= 1'b0;
        end else begin
            h_q  <= padin;
            ie_q <= ie;
        end
    end

    // Falling-edge capture of the low half; only read back through the FIFO write path
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            l_q <= '0;
        end else begin
            l_q <= padin;
        end
    end

    // Pop and overflow qualification
    always_comb begin
        pop_s      = dout_valid && dout_ready;
        overflow_s = ie_q && full_s && !pop_s;
    end

    jtframe_ddio_rx_fifo #(
        .W     (2*DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ie_q),
        .pop   (pop_s),
        .wdata ({h_q, l_q}),
        .head  (dout),
        .valid (dout_valid),
        .level (level),
        .full  (full_s)
    );

    // Sticky overflow flag; a fresh overflow beats a clear request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (overflow_s) begin
            ovf_r <= 1'b1;
        end else if (clr_ovf) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ovf = ovf_r;

`ifdef JTFRAME_DDIO_RX_STATS_EN
    logic [15:0] drops_r;

    // Dropped-word counter, cleared with ovf unless a drop happens that cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drops_r <= 16'd0;
        end else if (overflow_s) begin
            drops_r <= sat_inc16(drops_r);
        end else if (clr_ovf) begin
            drops_r <= 16'd0;
        end else begin
            drops_r <= drops_r;
        end
    end

    assign drops = drops_r;
`else
    assign drops = 16'd0;
`endif

endmodule

// File: tb/tb_jtframe_ddio_rx12.sv
// Directed self-checking bench for jtframe_ddio_rx12 (DW=12, DEPTH=4).
module tb_jtframe_ddio_rx12;
    import jtframe_ddio_rx_pkg::*;

    logic        clk;
    logic        rst;
    logic [11:0] padin;
    logic        ie;
    logic [23:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [2:0]  level;
    logic        ovf;
    logic        clr_ovf;
    logic [15:0] drops;

    int n_checks = 0;
    int n_errors = 0;

`ifdef JTFRAME_DDIO_RX_STATS_EN
    localparam logic [15:0] DROPS_AFTER_FILL = 16'd2;
    localparam logic [15:0] DROPS_AFTER_CLR  = 16'd3;
`else
    localparam logic [15:0] DROPS_AFTER_FILL = 16'd0;
    localparam logic [15:0] DROPS_AFTER_CLR  = 16'd0;
`endif

    jtframe_ddio_rx12 dut (
        .clk        (clk),
        .rst        (rst),
        .padin      (padin),
        .ie         (ie),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .level      (level),
        .ovf        (ovf),
        .clr_ovf    (clr_ovf),
        .drops      (drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle, entered and left 1 time unit after a falling edge
    task automatic cyc(input logic [11:0] h, input logic [11:0] l, input logic e,
                       input logic rdy, input logic clr);
        padin      = h;
        ie         = e;
        dout_ready = rdy;
        clr_ovf    = clr;
        @(posedge clk);
        #1;
        padin = l;
        @(negedge clk);
        #1;
    endtask

    word_t exp_q[4];

    initial begin
        rst        = 1'b1;
        padin      = 12'h000;
        ie         = 1'b0;
        dout_ready = 1'b0;
        clr_ovf    = 1'b0;
        @(negedge clk);
        #1;
        check_val("rst_valid", 32'(dout_valid), 32'h0);
        check_val("rst_level", 32'(level), 32'h0);
        check_val("rst_ovf", 32'(ovf), 32'h0);
        check_val("rst_drops", 32'(drops), 32'h0);
        check_val("rst_dout", 32'(dout), 32'h0);
        rst = 1'b0;
        cyc(12'h000, 12'h000, 1'b0, 1'b0, 1'b0);

        // Single word
        cyc(12'hABC, 12'h123, 1'b1, 1'b0, 1'b0);
        check_val("single_latency_valid", 32'(dout_valid), 32'h0);
        cyc(12'h000, 12'h000, 1'b0, 1'b0, 1'b0);
        check_val("single_dout", 32'(dout), 32'hABC123);
        check_val("single_valid", 32'(dout_valid), 32'h1);
        check_val("single_level", 32'(level), 32'h1);
        cyc(12'h000, 12'h000, 1'b0, 1'b0, 1'b0);
        check_val("single_hold", 32'(dout), 32'hABC123);
        cyc(12'h000, 12'h000, 1'b0, 1'b1, 1'b0);
        check_val("single_drain_level", 32'(level), 32'h0);
        check_val("single_drain_valid", 32'(dout_valid), 32'h0);

        // Six words into a four-deep FIFO
        for (int i = 0; i < 6; i++) begin
            cyc(12'(i), 12'(i + 16'h100), 1'b1, 1'b0, 1'b0);
        end
        cyc(12'h000, 12'h000, 1'b0, 1'b0, 1'b0);
        check_val("fill_level", 32'(level), 32'h4);
        check_val("fill_ovf", 32'(ovf), 32'h1);
        check_val("fill_drops", 32'(drops), 32'(DROPS_AFTER_FILL));
        check_val("fill_head", 32'(dout), 32'h000100);

        // Overflow concurrent with clear keeps ovf, then clear alone
        cyc(12'h005, 12'h006, 1'b1, 1'b0, 1'b0);
        cyc(12'h000, 12'h000, 1'b0, 1'b0, 1'b1);
        check_val("clr_race_ovf", 32'(ovf), 32'h1);
        check_val("clr_race_drops", 32'(drops), 32'(DROPS_AFTER_CLR));
        check_val("clr_race_level", 32'(level), 32'h4);
        cyc(12'h000, 12'h000, 1'b0, 1'b0, 1'b1);
        check_val("clr_ovf", 32'(ovf), 32'h0);
        check_val("clr_drops", 32'(drops), 32'h0);

        // Push into a full FIFO while popping
        cyc(12'hAAA, 12'hBBB, 1'b1, 1'b0, 1'b0);
        cyc(12'h000, 12'h000, 1'b0, 1'b1, 1'b0);
        check_val("fullpp_level", 32'(level), 32'h4);
        check_val("fullpp_ovf", 32'(ovf), 32'h0);
        check_val("fullpp_head", 32'(dout), 32'h001101);
        exp_q[0] = 24'h001101;
        exp_q[1] = 24'h002102;
        exp_q[2] = 24'h003103;
        exp_q[3] = 24'hAAABBB;
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("drain_word%0d", k), 32'(dout), 32'(exp_q[k]));
            check_val($sformatf("drain_valid%0d", k), 32'(dout_valid), 32'h1);
            cyc(12'h000, 12'h000, 1'b0, 1'b1, 1'b0);
        end
        check_val("drain_empty", 32'(level), 32'h0);

        // Asynchronous reset mid-stream with three words stored
        for (int i = 0; i < 3; i++) begin
            cyc(12'h111 * 12'(i + 1), 12'h222, 1'b1, 1'b0, 1'b0);
        end
        cyc(12'h777, 12'h888, 1'b1, 1'b0, 1'b0);
        check_val("prerst_level", 32'(level), 32'h3);
        rst = 1'b1;
        #1;
        check_val("arst_valid", 32'(dout_valid), 32'h0);
        check_val("arst_level", 32'(level), 32'h0);
        check_val("arst_ovf", 32'(ovf), 32'h0);
        #1;
        rst = 1'b0;
        cyc(12'h000, 12'h000, 1'b0, 1'b0, 1'b0);
        check_val("postrst_discard", 32'(level), 32'h0);
        cyc(12'h321, 12'h654, 1'b1, 1'b0, 1'b0);
        cyc(12'h000, 12'h000, 1'b0, 1'b0, 1'b0);
        check_val("postrst_word", 32'(dout), 32'h321654);
        check_val("postrst_level", 32'(level), 32'h1);
        cyc(12'h000, 12'h000, 1'b0, 1'b1, 1'b0);

        // ie toggling 1,0,1 with continuous ready
        cyc(12'h1A1, 12'h1B1, 1'b1, 1'b1, 1'b0);
        check_val("tog_c0_valid", 32'(dout_valid), 32'h0);
        cyc(12'h000, 12'h000, 1'b0, 1'b1, 1'b0);
        check_val("tog_c1_valid", 32'(dout_valid), 32'h1);
        check_val("tog_c1_dout", 32'(dout), 32'h1A11B1);
        cyc(12'h2A2, 12'h2B2, 1'b1, 1'b1, 1'b0);
        check_val("tog_c2_valid", 32'(dout_valid), 32'h0);
        cyc(12'h000, 12'h000, 1'b0, 1'b1, 1'b0);
        check_val("tog_c3_valid", 32'(dout_valid), 32'h1);
        check_val("tog_c3_dout", 32'(dout), 32'h2A22B2);
        cyc(12'h000, 12'h000, 1'b0, 1'b1, 1'b0);
        check_val("tog_c4_valid", 32'(dout_valid), 32'h0);
        check_val("tog_c4_level", 32'(level), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
